// File: rtl/mesh_ingress_arb_pkg.sv
// ----------------------------------------------------------------------------
// mesh_pkg
// Shared definitions for the mesh ingress concentrator:
//   - header field geometry of the broadcast marker byte (top byte of a packet)
//   - default broadcast marker value
//   - arbitration mode encoding
//   - saturating 16-bit increment used by the broadcast counter
// No ports; imported by mesh_sync_fifo and mesh_ingress_arb.
// ----------------------------------------------------------------------------
package mesh_pkg;

    // The broadcast marker lives in the most significant byte of a packet,
    // i.e. slice [pckg_sz-1 -: BDCST_FIELD_W].
    localparam int BDCST_FIELD_W = 8;

    // Header value that marks a packet as broadcast unless overridden.
    localparam logic [BDCST_FIELD_W-1:0] BDCST_DEFAULT = 8'hFF;

    // Arbitration modes selectable through the ARB_MODE parameter.
    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/mesh_sync_fifo.sv
// ----------------------------------------------------------------------------
// mesh_sync_fifo
// One-channel synchronous FIFO used per source channel of the ingress
// concentrator. Depth must be a power of two so the pointers wrap naturally.
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   synchronous active-low reset (0 = reset), empties the FIFO
//   push   in   write din this edge (ignored while full)
//   pop    in   advance the head this edge (ignored while empty)
//   din    in   WIDTH-bit write data
//   dout   out  current head entry (valid while !empty)
//   full   out  occupancy == DEPTH, derived from the registered count only
//   empty  out  occupancy == 0, derived from the registered count only
//   count  out  registered occupancy 0..DEPTH
// ----------------------------------------------------------------------------
module mesh_sync_fifo
    import mesh_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Flags come purely from the registered count, so the caller sees a
    // full flag that cannot react to a read happening on the same edge.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping. A simultaneous push and pop leaves
    // the count unchanged; the pop consumes the old head because the read
    // pointer addresses the entry that was already stored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array. No reset needed: entries are only ever observed
    // after they have been written, since the count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/mesh_ingress_arb.sv
// ----------------------------------------------------------------------------
// mesh_ingress_arb
// N-channel ingress concentrator. Each terminal source is drained over the
// pending/pop handshake into its own FIFO; the buffered packets are merged
// onto one mesh-side port by a round-robin or fixed-priority arbiter feeding
// a registered output stage. Broadcast packets are counted as they leave.
//
// Ports:
//   clk            in   single clock, rising edge
//   reset          in   synchronous active-low reset (0 = reset)
//   pndng_i_in     in   [NUM_CH]          source c holds a valid packet
//   data_out_i_in  in   [NUM_CH*pckg_sz]  packet of source c at slice c
//   pop            out  [NUM_CH]          consume pulse to source c
//   pndng          out  output word valid
//   data_out       out  [pckg_sz]         output packet
//   popin          in   mesh side takes data_out this edge
//   out_ch         out  [$clog2(NUM_CH)]  source channel of data_out
//   fill           out  [NUM_CH*CNT_W]    per-channel FIFO occupancy
//   bdcst_cnt      out  [16]              delivered broadcasts, saturating
// ----------------------------------------------------------------------------
module mesh_ingress_arb
    import mesh_pkg::*;
#(
    parameter int                         pckg_sz    = 32,
    parameter int                         fifo_depth = 4,
    parameter int                         NUM_CH     = 4,
    parameter int                         ARB_MODE   = 0,
    parameter logic [BDCST_FIELD_W-1:0]   bdcst      = BDCST_DEFAULT,
    localparam int                        CNT_W      = $clog2(fifo_depth + 1),
    localparam int                        CH_W       = $clog2(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           pndng_i_in,
    input  logic [NUM_CH*pckg_sz-1:0]   data_out_i_in,
    output logic [NUM_CH-1:0]           pop,
    output logic                        pndng,
    output logic [pckg_sz-1:0]          data_out,
    input  logic                        popin,
    output logic [CH_W-1:0]             out_ch,
    output logic [NUM_CH*CNT_W-1:0]     fill,
    output logic [15:0]                 bdcst_cnt
);

    localparam bit USE_FIXED = (ARB_MODE == int'(ARB_FIXED));

    logic [NUM_CH-1:0]   ch_full;
    logic [NUM_CH-1:0]   ch_empty;
    logic [NUM_CH-1:0]   ch_rd;
    logic [pckg_sz-1:0]  ch_head  [NUM_CH];
    logic [CNT_W-1:0]    ch_count [NUM_CH];

    logic [CH_W-1:0]     grant;
    logic                grant_vld;
    logic                load;
    logic                consume;
    int                  search_idx;

    logic                pndng_q;
    logic [pckg_sz-1:0]  data_q;
    logic [CH_W-1:0]     out_ch_q;
    logic [CH_W-1:0]     rr_ptr;
    logic [15:0]         bdcst_q;

    // Ingress handshake: a source is popped whenever it is pending and its
    // FIFO was not full at the last edge. Held low during reset so nothing
    // is taken from a source while the buffers are being discarded.
    assign pop = pndng_i_in & ~ch_full & {NUM_CH{reset}};

    // One FIFO per source channel; the fill vector is just the registered
    // FIFO occupancies laid side by side.
    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            mesh_sync_fifo #(
                .WIDTH (pckg_sz),
                .DEPTH (fifo_depth)
            ) u_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (pop[c]),
                .pop   (ch_rd[c]),
                .din   (data_out_i_in[c*pckg_sz +: pckg_sz]),
                .dout  (ch_head[c]),
                .full  (ch_full[c]),
                .empty (ch_empty[c]),
                .count (ch_count[c])
            );
            assign fill[c*CNT_W +: CNT_W] = ch_count[c];
        end
    endgenerate

    // Arbiter. Both searches walk their candidates in reverse order and let
    // later hits overwrite earlier ones, so the surviving grant is the first
    // non-empty channel in the intended search order. Round-robin starts one
    // past the last granted channel; fixed priority favours index 0.
    always_comb begin
        grant      = '0;
        grant_vld  = 1'b0;
        search_idx = 0;
        if (USE_FIXED) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (!ch_empty[i]) begin
                    grant     = CH_W'(i);
                    grant_vld = 1'b1;
                end
            end
        end else begin
            for (int i = NUM_CH; i >= 1; i--) begin
                search_idx = (int'(rr_ptr) + i) % NUM_CH;
                if (!ch_empty[search_idx]) begin
                    grant     = CH_W'(search_idx);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    // The output stage accepts a new word when it is empty or its current
    // word is being taken this edge; popin with no valid word is a no-op.
    assign consume = pndng_q & popin;
    assign load    = reset & (~pndng_q | popin) & grant_vld;

    // Read strobe back into the granted FIFO, aligned with the load edge.
    always_comb begin
        ch_rd = '0;
        if (load) begin
            ch_rd[grant] = 1'b1;
        end
    end

    // Registered output stage, round-robin pointer and broadcast counter.
    // The broadcast test looks at the word leaving the stage, so a packet
    // is counted exactly once, on the edge the mesh side takes it. The
    // pointer resets to the last channel so channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pndng_q  <= 1'b0;
            data_q   <= '0;
            out_ch_q <= '0;
            rr_ptr   <= CH_W'(NUM_CH - 1);
            bdcst_q  <= '0;
        end else begin
            if (consume && (data_q[pckg_sz-1 -: BDCST_FIELD_W] == bdcst)) begin
                bdcst_q <= sat_inc16(bdcst_q);
            end
            if (load) begin
                pndng_q  <= 1'b1;
                data_q   <= ch_head[grant];
                out_ch_q <= grant;
                rr_ptr   <= grant;
            end else if (consume) begin
                pndng_q <= 1'b0;
            end
        end
    end

    assign pndng     = pndng_q;
    assign data_out  = data_q;
    assign out_ch    = out_ch_q;
    assign bdcst_cnt = bdcst_q;

endmodule

// File: tb/tb_mesh_ingress_arb.sv
// ----------------------------------------------------------------------------
// tb_mesh_ingress_arb
// Directed bench for mesh_ingress_arb. Two instances share clock and reset:
// dut runs round-robin, dut_fp runs fixed priority. Each source channel is a
// small counter model that presents {header, channel, sequence} and moves to
// its next packet when it sees a pop.
// ----------------------------------------------------------------------------
module tb_mesh_ingress_arb;

    localparam int NCH   = 4;
    localparam int PW    = 32;
    localparam int CW    = 3;
    localparam int BIG   = 1000000;

    logic                clk = 1'b0;
    logic                reset;

    logic [NCH-1:0]      pndng_i_in;
    logic [NCH*PW-1:0]   data_out_i_in;
    logic [NCH-1:0]      pop;
    logic                pndng;
    logic [PW-1:0]       data_out;
    logic                popin;
    logic [1:0]          out_ch;
    logic [NCH*CW-1:0]   fill;
    logic [15:0]         bdcst_cnt;

    logic [NCH-1:0]      fpPndngIn;
    logic [NCH*PW-1:0]   fpDataIn;
    logic [NCH-1:0]      fpPop;
    logic                fpPndng;
    logic [PW-1:0]       fpDataOut;
    logic                fpPopin;
    logic [1:0]          fpOutCh;
    logic [NCH*CW-1:0]   fpFill;
    logic [15:0]         fpBdcstCnt;

    int                  srcLeft [NCH];
    int                  srcIdx  [NCH];
    logic [7:0]          srcHdr  [NCH];
    int                  fpLeft  [NCH];
    int                  fpIdx   [NCH];

    int                  checkCount = 0;
    int                  passCount  = 0;

    int                  expBc [5] = '{1, 1, 2, 2, 3};
    int                  expBcCh [4] = '{1, 0, 1, 0};
    int                  expFpCh [6] = '{1, 1, 1, 3, 3, 3};
    int                  expFpSeq [6] = '{0, 1, 2, 0, 1, 2};

    always #5 clk = ~clk;

    mesh_ingress_arb #(
        .pckg_sz    (PW),
        .fifo_depth (4),
        .NUM_CH     (NCH),
        .ARB_MODE   (0),
        .bdcst      (8'hFF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pndng_i_in    (pndng_i_in),
        .data_out_i_in (data_out_i_in),
        .pop           (pop),
        .pndng         (pndng),
        .data_out      (data_out),
        .popin         (popin),
        .out_ch        (out_ch),
        .fill          (fill),
        .bdcst_cnt     (bdcst_cnt)
    );

    mesh_ingress_arb #(
        .pckg_sz    (PW),
        .fifo_depth (4),
        .NUM_CH     (NCH),
        .ARB_MODE   (1),
        .bdcst      (8'hFF)
    ) dut_fp (
        .clk           (clk),
        .reset         (reset),
        .pndng_i_in    (fpPndngIn),
        .data_out_i_in (fpDataIn),
        .pop           (fpPop),
        .pndng         (fpPndng),
        .data_out      (fpDataOut),
        .popin         (fpPopin),
        .out_ch        (fpOutCh),
        .fill          (fpFill),
        .bdcst_cnt     (fpBdcstCnt)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present each source model's current packet on the DUT inputs.
    task automatic applyStimulus();
        for (int c = 0; c < NCH; c++) begin
            pndng_i_in[c] = (srcLeft[c] != 0);
            data_out_i_in[c*PW +: PW] = {srcHdr[c], 8'(c), 16'(srcIdx[c])};
            fpPndngIn[c] = (fpLeft[c] != 0);
            fpDataIn[c*PW +: PW] = {8'h20, 8'(c), 16'(fpIdx[c])};
        end
    endtask

    // One clock: sample pops before the edge, advance the sources that were
    // popped, re-drive inputs, and return 2 time units after the edge.
    task automatic stepCycle();
        logic [NCH-1:0] seen;
        logic [NCH-1:0] fpSeen;
        @(negedge clk);
        seen   = pop;
        fpSeen = fpPop;
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (seen[c]) begin
                srcIdx[c]++;
                if (srcLeft[c] > 0) srcLeft[c]--;
            end
            if (fpSeen[c]) begin
                fpIdx[c]++;
                if (fpLeft[c] > 0) fpLeft[c]--;
            end
        end
        applyStimulus();
        #1;
    endtask

    task automatic doReset();
        for (int c = 0; c < NCH; c++) begin
            srcLeft[c] = 0;
            srcIdx[c]  = 0;
            srcHdr[c]  = 8'h00;
            fpLeft[c]  = 0;
            fpIdx[c]   = 0;
        end
        popin   = 1'b0;
        fpPopin = 1'b0;
        reset   = 1'b0;
        applyStimulus();
        stepCycle();
        reset = 1'b1;
    endtask

    initial begin
        // ---------------- reset with every source pending ----------------
        reset   = 1'b0;
        popin   = 1'b1;
        fpPopin = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            srcLeft[c] = BIG;
            srcIdx[c]  = 0;
            srcHdr[c]  = 8'h10;
            fpLeft[c]  = 0;
            fpIdx[c]   = 0;
        end
        applyStimulus();
        stepCycle();
        stepCycle();
        checkOutput("rst pop", 64'(pop), 64'h0);
        checkOutput("rst pndng", 64'(pndng), 64'h0);
        checkOutput("rst fill", 64'(fill), 64'h0);
        checkOutput("rst bdcst_cnt", 64'(bdcst_cnt), 64'h0);
        checkOutput("rst data_out", 64'(data_out), 64'h0);
        checkOutput("rst out_ch", 64'(out_ch), 64'h0);
        checkOutput("rst fp pndng", 64'(fpPndng), 64'h0);

        // ---------------- round-robin fairness ----------------
        reset = 1'b1;
        stepCycle();
        checkOutput("rr first pndng", 64'(pndng), 64'h0);
        checkOutput("rr first fill", 64'(fill), 64'h249);
        for (int k = 0; k < 8; k++) begin
            stepCycle();
            checkOutput("rr pndng", 64'(pndng), 64'h1);
            checkOutput("rr out_ch", 64'(out_ch), 64'(k % 4));
            checkOutput("rr data", 64'(data_out), 64'({8'h10, 8'(k % 4), 16'(k / 4)}));
        end
        checkOutput("rr no bdcst", 64'(bdcst_cnt), 64'h0);

        // ---------------- fixed priority ----------------
        doReset();
        fpLeft[1] = 3;
        fpLeft[3] = 3;
        fpPopin   = 1'b1;
        applyStimulus();
        stepCycle();
        for (int k = 0; k < 6; k++) begin
            stepCycle();
            checkOutput("fp pndng", 64'(fpPndng), 64'h1);
            checkOutput("fp out_ch", 64'(fpOutCh), 64'(expFpCh[k]));
            checkOutput("fp data", 64'(fpDataOut),
                        64'({8'h20, 8'(expFpCh[k]), 16'(expFpSeq[k])}));
        end
        stepCycle();
        checkOutput("fp drained", 64'(fpPndng), 64'h0);

        // ---------------- backpressure on channel 2 ----------------
        doReset();
        srcLeft[2] = 10;
        srcHdr[2]  = 8'h40;
        applyStimulus();
        for (int k = 0; k < 10; k++) stepCycle();
        checkOutput("bp fill full", 64'(fill), 64'h100);
        checkOutput("bp pop held", 64'(pop), 64'h0);
        checkOutput("bp pndng", 64'(pndng), 64'h1);
        checkOutput("bp head", 64'(data_out), 64'h4002_0000);
        popin = 1'b1;
        for (int k = 1; k < 10; k++) begin
            stepCycle();
            checkOutput("bp order", 64'(data_out), 64'({8'h40, 8'h02, 16'(k)}));
            checkOutput("bp out_ch", 64'(out_ch), 64'h2);
        end
        stepCycle();
        checkOutput("bp drained", 64'(pndng), 64'h0);
        checkOutput("bp fill empty", 64'(fill), 64'h0);

        // ---------------- broadcast accounting ----------------
        doReset();
        srcLeft[0] = 3;
        srcHdr[0]  = 8'hFF;
        srcLeft[1] = 2;
        srcHdr[1]  = 8'h05;
        applyStimulus();
        for (int k = 0; k < 3; k++) stepCycle();
        checkOutput("bc held pndng", 64'(pndng), 64'h1);
        checkOutput("bc held out_ch", 64'(out_ch), 64'h0);
        checkOutput("bc not yet", 64'(bdcst_cnt), 64'h0);
        popin = 1'b1;
        for (int k = 0; k < 5; k++) begin
            stepCycle();
            checkOutput("bc count", 64'(bdcst_cnt), 64'(expBc[k]));
            if (k < 4) checkOutput("bc out_ch", 64'(out_ch), 64'(expBcCh[k]));
        end
        stepCycle();
        checkOutput("bc final", 64'(bdcst_cnt), 64'h3);
        checkOutput("bc drained", 64'(pndng), 64'h0);

        // ---------------- mid-stream reset ----------------
        doReset();
        srcLeft[1] = 3;
        srcHdr[1]  = 8'h30;
        applyStimulus();
        for (int k = 0; k < 3; k++) stepCycle();
        checkOutput("mid pndng", 64'(pndng), 64'h1);
        checkOutput("mid fill", 64'(fill), 64'h010);
        checkOutput("mid data", 64'(data_out), 64'h3001_0000);
        srcLeft[3] = 2;
        reset = 1'b0;
        applyStimulus();
        #1;
        checkOutput("mid rst pop", 64'(pop), 64'h0);
        stepCycle();
        checkOutput("mid rst pndng", 64'(pndng), 64'h0);
        checkOutput("mid rst fill", 64'(fill), 64'h0);
        srcLeft[3] = 0;
        applyStimulus();
        reset = 1'b1;
        popin = 1'b1;
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            checkOutput("mid no ghost", 64'(pndng), 64'h0);
        end

        // ---------------- broadcast counter saturation ----------------
        doReset();
        for (int c = 0; c < NCH; c++) begin
            srcLeft[c] = BIG;
            srcHdr[c]  = 8'hFF;
        end
        popin = 1'b1;
        applyStimulus();
        for (int n = 0; n < 70000 && bdcst_cnt != 16'hFFFF; n++) stepCycle();
        checkOutput("sat reach", 64'(bdcst_cnt), 64'hFFFF);
        for (int k = 0; k < 5; k++) stepCycle();
        checkOutput("sat streaming", 64'(pndng), 64'h1);
        checkOutput("sat hold", 64'(bdcst_cnt), 64'hFFFF);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
